// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - Tuse/Tnew stall controller and MDU busy sequencer for the 5-stage MIPS pipe.
// Optional stall-cycle counter port stall_cnt is built when HSU_PERF_CNT_EN is defined.
module hazard_stall_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] INS_D,
  input  logic [31:0] INS_E,
  input  logic [31:0] INS_M,
  output logic        pc_en,
  output logic        d_reg_en,
  output logic        e_reg_clr,
  output logic        mdu_start,
  output logic        mdu_is_div,
  output logic        mdu_busy
`ifdef HSU_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [3:0] {
    C_NONE, C_CAL_R, C_CAL_I, C_LOAD, C_STORE, C_BEQ,
    C_JR, C_JAL, C_MD, C_MF, C_MT
  } cls_e;

  function automatic cls_e classify(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    classify = C_NONE;
    case (op)
      6'h00: begin
        case (fn)
          6'h20, 6'h22:               classify = C_CAL_R;
          6'h08:                      classify = C_JR;
          6'h18, 6'h19, 6'h1a, 6'h1b: classify = C_MD;
          6'h10, 6'h12:               classify = C_MF;
          6'h11, 6'h13:               classify = C_MT;
          default:                    classify = C_NONE;
        endcase
      end
      6'h0d, 6'h0f: classify = C_CAL_I;
      6'h23:        classify = C_LOAD;
      6'h2b:        classify = C_STORE;
      6'h04:        classify = C_BEQ;
      6'h03:        classify = C_JAL;
      default:      classify = C_NONE;
    endcase
  endfunction

  // Instructions without a destination report r0, which can never match a live source.
  function automatic logic [4:0] dest_of(input logic [31:0] ins, input cls_e c);
    case (c)
      C_CAL_R, C_MF:  dest_of = ins[15:11];
      C_CAL_I, C_LOAD: dest_of = ins[20:16];
      C_JAL:          dest_of = 5'd31;
      default:        dest_of = 5'd0;
    endcase
  endfunction

  cls_e       cls_d, cls_e_stg, cls_m;
  logic [4:0] dst_e, dst_m;
  logic [1:0] tnew_e, tnew_m;
  logic [1:0] tuse_rs, tuse_rt;
  logic       rd_rs, rd_rt;
  logic       haz_rs, haz_rt, data_stall, mdu_stall, stall;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       unused_bits;

  assign cls_d     = classify(INS_D);
  assign cls_e_stg = classify(INS_E);
  assign cls_m     = classify(INS_M);
  assign dst_e     = dest_of(INS_E, cls_e_stg);
  assign dst_m     = dest_of(INS_M, cls_m);

  assign tnew_e = (cls_e_stg == C_LOAD) ? 2'd2 :
                  (cls_e_stg == C_CAL_R || cls_e_stg == C_CAL_I || cls_e_stg == C_MF) ? 2'd1 : 2'd0;
  assign tnew_m = (cls_m == C_LOAD) ? 2'd1 : 2'd0;

  always_comb begin
    rd_rs   = 1'b0;
    rd_rt   = 1'b0;
    tuse_rs = 2'd0;
    tuse_rt = 2'd0;
    case (cls_d)
      C_BEQ:          begin rd_rs = 1'b1; rd_rt = 1'b1; end
      C_JR:           rd_rs = 1'b1;
      C_CAL_R, C_MD:  begin rd_rs = 1'b1; rd_rt = 1'b1; tuse_rs = 2'd1; tuse_rt = 2'd1; end
      C_CAL_I, C_LOAD, C_MT: begin rd_rs = 1'b1; tuse_rs = 2'd1; end
      C_STORE:        begin rd_rs = 1'b1; rd_rt = 1'b1; tuse_rs = 2'd1; tuse_rt = 2'd2; end
      default:        ;
    endcase
  end

  assign haz_rs = rd_rs && (INS_D[25:21] != 5'd0) &&
                  ((INS_D[25:21] == dst_e && tuse_rs < tnew_e) ||
                   (INS_D[25:21] == dst_m && tuse_rs < tnew_m));
  assign haz_rt = rd_rt && (INS_D[20:16] != 5'd0) &&
                  ((INS_D[20:16] == dst_e && tuse_rt < tnew_e) ||
                   (INS_D[20:16] == dst_m && tuse_rt < tnew_m));

  assign data_stall = haz_rs | haz_rt;
  assign mdu_start  = (cls_e_stg == C_MD) & reset_n;
  assign mdu_is_div = INS_E[1];
  assign mdu_busy   = (cnt_q != '0);
  assign mdu_stall  = (cls_d == C_MD || cls_d == C_MF || cls_d == C_MT) & (mdu_start | mdu_busy);
  assign stall      = data_stall | mdu_stall;

  assign pc_en     = ~stall;
  assign d_reg_en  = ~stall;
  assign e_reg_clr = stall;

  always_comb begin
    cnt_d = cnt_q;
    if (mdu_start)
      cnt_d = mdu_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

`ifdef HSU_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
  assign stall_cnt   = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end
`endif

  assign unused_bits = ^{INS_D[15:6], INS_E[25:21], INS_E[10:6], INS_M[25:21], INS_M[10:6]};

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed scoreboard bench for hazard_stall_unit.
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ins_d, ins_e, ins_m;
  logic        pc_en, d_reg_en, e_reg_clr, mdu_start, mdu_is_div, mdu_busy;
`ifdef HSU_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  hazard_stall_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .INS_D      (ins_d),
    .INS_E      (ins_e),
    .INS_M      (ins_m),
    .pc_en      (pc_en),
    .d_reg_en   (d_reg_en),
    .e_reg_clr  (e_reg_clr),
    .mdu_start  (mdu_start),
    .mdu_is_div (mdu_is_div),
    .mdu_busy   (mdu_busy)
`ifdef HSU_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  localparam logic [31:0] NOP    = 32'h0;
  localparam logic [31:0] LW1    = {6'h23, 5'd0, 5'd1, 16'd0};
  localparam logic [31:0] LW2    = {6'h23, 5'd0, 5'd2, 16'd0};
  localparam logic [31:0] LW0    = {6'h23, 5'd0, 5'd0, 16'd0};
  localparam logic [31:0] ADD2   = {6'h00, 5'd1, 5'd3, 5'd2, 5'd0, 6'h20};
  localparam logic [31:0] ADD1   = {6'h00, 5'd3, 5'd4, 5'd1, 5'd0, 6'h20};
  localparam logic [31:0] BEQ12  = {6'h04, 5'd1, 5'd2, 16'd0};
  localparam logic [31:0] BEQ00  = {6'h04, 5'd0, 5'd0, 16'd0};
  localparam logic [31:0] ORI0   = {6'h0d, 5'd3, 5'd0, 16'd1};
  localparam logic [31:0] JAL    = {6'h03, 26'd4};
  localparam logic [31:0] JR31   = {6'h00, 5'd31, 15'd0, 6'h08};
  localparam logic [31:0] SW12   = {6'h2b, 5'd2, 5'd1, 16'd0};
  localparam logic [31:0] MULT   = {6'h00, 5'd4, 5'd5, 10'd0, 6'h18};
  localparam logic [31:0] MULT12 = {6'h00, 5'd1, 5'd2, 10'd0, 6'h18};
  localparam logic [31:0] MULTU  = {6'h00, 5'd4, 5'd5, 10'd0, 6'h19};
  localparam logic [31:0] DIV    = {6'h00, 5'd4, 5'd5, 10'd0, 6'h1a};
  localparam logic [31:0] MFLO   = {6'h00, 10'd0, 5'd6, 5'd0, 6'h12};
  localparam logic [31:0] MFHI   = {6'h00, 10'd0, 5'd6, 5'd0, 6'h10};

  typedef struct packed {
    logic stall;
    logic start;
    logic is_div;
    logic busy;
  } exp_t;

  exp_t  sbq[$];
  string tagq[$];
  int    checks = 0;
  int    errors = 0;
  int    stall_obs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_head();
    exp_t  e;
    string t;
    e = sbq.pop_front();
    t = tagq.pop_front();
    chk({t, ".pc_en"},     {31'd0, pc_en},     {31'd0, ~e.stall});
    chk({t, ".d_reg_en"},  {31'd0, d_reg_en},  {31'd0, ~e.stall});
    chk({t, ".e_reg_clr"}, {31'd0, e_reg_clr}, {31'd0, e.stall});
    chk({t, ".mdu_start"}, {31'd0, mdu_start}, {31'd0, e.start});
    chk({t, ".mdu_busy"},  {31'd0, mdu_busy},  {31'd0, e.busy});
    if (e.start) chk({t, ".mdu_is_div"}, {31'd0, mdu_is_div}, {31'd0, e.is_div});
    stall_obs += int'(e_reg_clr);
  endtask

  task automatic step(input logic rn, input logic [31:0] d, input logic [31:0] e,
                      input logic [31:0] m, input logic s, input logic st,
                      input logic dv, input logic b, input string tag);
    reset_n = rn;
    ins_d   = d;
    ins_e   = e;
    ins_m   = m;
    sbq.push_back('{stall: s, start: st, is_div: dv, busy: b});
    tagq.push_back(tag);
    @(negedge clk);
    compare_head();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    ins_d = NOP; ins_e = NOP; ins_m = NOP;
    repeat (2) @(posedge clk);
    #1;
    step(1'b0, NOP, NOP, NOP, 0, 0, 0, 0, "reset");
`ifdef HSU_PERF_CNT_EN
    chk("perf_reset", stall_cnt, 32'd0);
`endif

    step(1'b1, ADD2, LW1, NOP, 1, 0, 0, 0, "lwadd_e");
    step(1'b1, ADD2, NOP, LW1, 0, 0, 0, 0, "lwadd_m");

    stall_obs = 0;
    step(1'b1, MFLO, MULT, NOP, 1, 1, 0, 0, "mult_start");
    for (int i = 0; i < 5; i++) step(1'b1, MFLO, NOP, NOP, 1, 0, 0, 1, "mult_busy");
    step(1'b1, MFLO, NOP, NOP, 0, 0, 0, 0, "mult_done");
    chk("mult_total", stall_obs, 32'd6);
`ifdef HSU_PERF_CNT_EN
    chk("perf_total", stall_cnt, 32'd7);
`endif

    step(1'b1, BEQ12, LW1, NOP, 1, 0, 0, 0, "lwbeq_e");
    step(1'b1, BEQ12, NOP, LW1, 1, 0, 0, 0, "lwbeq_m");
    step(1'b1, BEQ12, NOP, NOP, 0, 0, 0, 0, "lwbeq_done");
    step(1'b1, BEQ12, ADD1, NOP, 1, 0, 0, 0, "addbeq_e");
    step(1'b1, BEQ12, NOP, ADD1, 0, 0, 0, 0, "addbeq_m");
    step(1'b1, JR31, JAL, NOP, 0, 0, 0, 0, "jaljr_e");
    step(1'b1, JR31, NOP, JAL, 0, 0, 0, 0, "jaljr_m");
    step(1'b1, SW12, LW1, NOP, 0, 0, 0, 0, "sw_rt");
    step(1'b1, SW12, LW2, NOP, 1, 0, 0, 0, "sw_rs_e");
    step(1'b1, SW12, NOP, LW2, 0, 0, 0, 0, "sw_rs_m");
    step(1'b1, BEQ00, ORI0, LW0, 0, 0, 0, 0, "r0_dest");

    stall_obs = 0;
    step(1'b1, MULTU, DIV, NOP, 1, 1, 1, 0, "div_start");
    for (int i = 0; i < 10; i++) step(1'b1, MULTU, NOP, NOP, 1, 0, 0, 1, "div_busy");
    step(1'b1, MULTU, NOP, NOP, 0, 0, 0, 0, "div_done");
    chk("div_total", stall_obs, 32'd11);

    stall_obs = 0;
    step(1'b1, NOP, MULT, NOP, 0, 1, 0, 0, "dual_bg");
    step(1'b1, MULT12, LW1, NOP, 1, 0, 0, 1, "dual_both");
    for (int i = 0; i < 4; i++) step(1'b1, MULT12, NOP, NOP, 1, 0, 0, 1, "dual_busy");
    step(1'b1, MULT12, NOP, NOP, 0, 0, 0, 0, "dual_done");
    chk("dual_total", stall_obs, 32'd5);

    step(1'b1, NOP, DIV, NOP, 0, 1, 1, 0, "rst_div_start");
    step(1'b1, NOP, NOP, NOP, 0, 0, 0, 1, "rst_busy1");
    step(1'b1, NOP, NOP, NOP, 0, 0, 0, 1, "rst_busy2");
    step(1'b0, NOP, MULT, NOP, 0, 0, 0, 1, "rst_mid");
    step(1'b1, MFHI, NOP, NOP, 0, 0, 0, 0, "mfhi_after_rst");

    chk("sb_empty", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall/bubble controller for the 5-stage MIPS pipeline. It decides when a consumer in D cannot be served by forwarding, and freezes the front end until the operand's producer is far enough down the pipe.
- Uses a Tuse/Tnew comparison against the instructions in E and M.
- Also owns the multi-cycle MDU busy sequencer, which blocks the HI/LO family in D while a mult/div is running.
- Sits beside the forwarding mux-select logic. It consumes the same raw instruction words and drives the PC, IF/ID and ID/EX pipeline-register controls.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu leaves E
DIV_CYCLES, 10, busy cycles after a div/divu leaves E
CNT_W, 4, width of busy counter; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  synchronous reset, active-low
INS_D  in  32  instruction word in D stage
INS_E  in  32  instruction word in E stage
INS_M  in  32  instruction word in M stage
pc_en  out  1  PC write enable (0 = hold)
d_reg_en  out  1  IF/ID register enable (0 = hold)
e_reg_clr  out  1  ID/EX clear, inserts a nop bubble into E
mdu_start  out  1  one-cycle start pulse to the MDU
mdu_is_div  out  1  valid with mdu_start: 1 = div/divu, 0 = mult/multu
mdu_busy  out  1  MDU counter nonzero
stall_cnt  out  32  stall-cycle counter; present only with HSU_PERF_CNT_EN

Behaviour:
- Decode classes:
  - cal_r: add/sub (funct 100000/100010); destination rd.
  - cal_i: ori/lui; destination rt.
  - load: lw; destination rt.
  - store: sw.
  - beq.
  - jr (funct 001000).
  - jal; destination 31.
  - md: mult/multu/div/divu (funct 011000-011011).
  - mf: mfhi/mflo; destination rd.
  - mt: mthi/mtlo.
  - Any other encoding, including all-zero nop, is no class: it reads nothing and writes nothing.
- Tuse, per source register (only the sources an instruction actually reads):
  - beq: rs=0, rt=0.
  - jr: rs=0.
  - cal_r, md: rs=1, rt=1.
  - cal_i, load, store, mt: rs=1.
  - store: rt=2.
- Tnew:
  - Producer in E: cal_r/cal_i/mf = 1, load = 2, jal = 0.
  - Producer in M: load = 1, all others = 0.
- Data stall: asserted if a source reg r of D satisfies all of:
  - r != 0;
  - r equals the destination of E and Tuse < Tnew_E, or r equals the destination of M and Tuse < Tnew_M.
- MDU stall: asserted if D is md/mf/mt AND (mdu_start OR mdu_busy).
- stall = data stall OR MDU stall. While stall=1: pc_en=0, d_reg_en=0, e_reg_clr=1. Otherwise pc_en=1, d_reg_en=1, e_reg_clr=0. These outputs are purely combinational, with no added latency.
- MDU sequencer:
  - E never stalls, so each md instruction occupies E for exactly one cycle.
  - mdu_start = (INS_E is md) AND reset_n.
  - mdu_is_div = INS_E funct[1].
  - On the clock edge where mdu_start=1, the counter loads DIV_CYCLES or MULT_CYCLES.
  - Otherwise a nonzero counter decrements by 1; zero holds.
  - mdu_busy = (count != 0).
  - A bubble in E never starts the MDU.
- Boundaries:
  - Reset (reset_n=0 at the edge) clears count to 0, including mid-operation; mdu_busy=0 the next cycle. While reset_n=0, mdu_start=0.
  - After reset: mdu_busy=0 and mdu_start=0. pc_en=1, d_reg_en=1 and e_reg_clr=0 hold unless a data hazard is present.
  - Data and MDU stall conditions simultaneously true: the outputs are identical to a single stall (no double counting).
  - An md in E plus an md in D: D stalls for 1 + N cycles.
  - Destination r0 never causes a stall.

Optional Feature:
- Macro HSU_PERF_CNT_EN.
- Defined:
  - stall_cnt port exists.
  - 32-bit register, reset to 0, increments by 1 at each clock edge where stall=1.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: the port and register are absent, and stall behaviour is identical.

Test Plan:
- lw $1,0($0) in E, add $2,$1,$3 in D:
  - 1 cycle with stall=1, e_reg_clr=1.
  - Next cycle (lw in M) stall=0, so forwarding resolves it.
- lw $1 in E, beq $1,$2 in D:
  - 2 stall cycles (E then M).
  - add $1 in E, beq $1 in D: 1 stall cycle.
  - jal in E, jr $31 in D: 0 stall cycles.
- sw $1,0($2) in D with lw $1 in E:
  - rt Tuse=2 gives no stall on rt.
  - Same with lw $2 in E gives 1 stall cycle (rs).
- mult in E, mflo in D:
  - mdu_start=1 and mdu_is_div=0, then mdu_busy=1 for 5 cycles.
  - Total stall = 6 cycles; with div instead, stall = 11.
- div started, reset_n=0 at the 3rd busy cycle:
  - count=0 and mdu_busy=0 next cycle.
  - A following mfhi in D is not stalled.
- With HSU_PERF_CNT_EN, run the lw/add + mult/mflo sequences:
  - stall_cnt = 7.
  - After reset, stall_cnt = 0.
